// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin front end for one shared 32-bit left shifter (SLL/SRL/SRA).
// Latency accept->rsp_valid 2 cycles (3 for negative SRA); a stalled response holds its data and blocks new grants.
module shift_arbiter #(
   parameter logic RESET_LAST_GRANT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [1:0]  req0_op,
   input  logic [31:0] req0_data,
   input  logic [4:0]  req0_shamt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [1:0]  req1_op,
   input  logic [31:0] req1_data,
   input  logic [4:0]  req1_shamt,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_id,
   output logic        busy,
   output logic [31:0] sh_data_in,
   output logic [4:0]  sh_shamt,
   input  logic [31:0] sh_data_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MASK  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_RSV = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   function automatic logic [31:0] bit_rev(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  shamt_q, shamt_d;
   logic        id_q, id_d;
   logic [31:0] result_q, result_d;

   logic gnt_vld;
   logic gnt_id;
   logic accept;
   logic is_right;
   logic needs_mask;

   always_comb begin
      gnt_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         gnt_id = ~last_grant_q;
      end else begin
         gnt_id = req1_valid;
      end
   end

   // Gated by rst_n so no ready can leak out while reset is held with a request pending.
   assign accept     = rst_n && (state_q == ST_IDLE) && gnt_vld;
   assign req0_ready = accept && !gnt_id;
   assign req1_ready = accept &&  gnt_id;

   assign is_right   = (op_q == OP_SRL) || (op_q == OP_SRA);
   assign needs_mask = (op_q == OP_SRA) && data_q[31] && (shamt_q != 5'd0);

   always_comb begin
      sh_data_in = '0;
      sh_shamt   = '0;
      case (state_q)
         ST_SHIFT: begin
            sh_data_in = is_right ? bit_rev(data_q) : data_q;
            sh_shamt   = (op_q == OP_RSV) ? 5'd0 : shamt_q;
         end
         ST_MASK: begin
            sh_data_in = 32'hFFFF_FFFF;
            sh_shamt   = shamt_q;
         end
         default: begin
            sh_data_in = '0;
            sh_shamt   = '0;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      data_d       = data_q;
      shamt_d      = shamt_q;
      id_d         = id_q;
      result_d     = result_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d         = gnt_id ? req1_op    : req0_op;
               data_d       = gnt_id ? req1_data  : req0_data;
               shamt_d      = gnt_id ? req1_shamt : req0_shamt;
               id_d         = gnt_id;
               last_grant_d = gnt_id;
               state_d      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            result_d = is_right ? bit_rev(sh_data_out) : sh_data_out;
            state_d  = needs_mask ? ST_MASK : ST_RESP;
         end
         ST_MASK: begin
            // Reversed (ones << shamt) has zeros in the top shamt bits; invert to get the sign fill.
            result_d = result_q | ~bit_rev(sh_data_out);
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= RESET_LAST_GRANT;
         op_q         <= '0;
         data_q       <= '0;
         shamt_q      <= '0;
         id_q         <= 1'b0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         data_q       <= data_d;
         shamt_q      <= shamt_d;
         id_q         <= id_d;
         result_q     <= result_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = result_q;
   assign rsp_id    = id_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
